// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: shared state encoding and control-bit indices for the skid stage
//   No ports; imported by pipe_entry_reg and pipe_stage_skid.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one payload register (ctrl/data/pc/rd) with load enable and synchronous clear
//   clk_i         rising-edge clock
//   clr_i         synchronous clear to zero, overrides load
//   ld_i          load the *_i payload
//   *_i / *_o     payload in / registered payload out
module pipe_entry_reg
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 2
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [RD_W-1:0]   rd_o
);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            ctrl_o <= '0;
            data_o <= '0;
            pc_o   <= '0;
            rd_o   <= '0;
        end else if (ld_i) begin
            ctrl_o <= ctrl_i;
            data_o <= data_i;
            pc_o   <= pc_i;
            rd_o   <= rd_i;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with a one-entry skid buffer
//   clk, reset            clock and synchronous active-high reset
//   flush                 drops all held entries and any same-cycle input
//   in_valid/in_ready     upstream handshake; in_ctrl/in_data/in_pc/in_rd payload
//   out_valid/out_ready   downstream handshake; out_ctrl/out_data/out_pc/out_rd payload
//   fwd_we/fwd_rd         write-enable and destination of the held entry for forwarding
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [RD_W-1:0]   out_rd,
    output logic              fwd_we,
    output logic [RD_W-1:0]   fwd_rd
);

    state_e state_q, state_d;
    logic in_fire, out_fire, main_ld, skid_ld;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, main_data_d;
    logic [PC_W-1:0]   skid_pc_q, main_pc_d;
    logic [RD_W-1:0]   skid_rd_q, main_rd_d;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = EMPTY;
        else if (state_q == EMPTY)
            state_d = in_fire ? ONE : EMPTY;
        else if (state_q == ONE)
            state_d = (in_fire & ~out_fire) ? TWO : (~in_fire & out_fire) ? EMPTY : ONE;
        else
            state_d = out_fire ? ONE : TWO;
    end

    // in_ready depends only on registered state, so no out_ready-to-in_ready path exists.
    always_comb begin
        in_ready  = (state_q != TWO);
        out_valid = (state_q != EMPTY);
        out_ctrl  = out_valid ? main_ctrl_q : '0;
        fwd_we    = out_valid & main_ctrl_q[CTRL_REGWRITE];
    end

    // Main refills from the skid when draining TWO, otherwise from the input.
    always_comb begin
        main_ld     = ~flush & ((state_q == EMPTY & in_fire) |
                                (state_q == ONE & in_fire & out_fire) |
                                (state_q == TWO & out_fire));
        skid_ld     = ~flush & (state_q == ONE) & in_fire & ~out_fire;
        main_ctrl_d = (state_q == TWO) ? skid_ctrl_q : in_ctrl;
        main_data_d = (state_q == TWO) ? skid_data_q : in_data;
        main_pc_d   = (state_q == TWO) ? skid_pc_q   : in_pc;
        main_rd_d   = (state_q == TWO) ? skid_rd_q   : in_rd;
    end

    pipe_entry_reg #(
        .DATA_W(DATA_W), .PC_W(PC_W), .RD_W(RD_W), .CTRL_W(CTRL_W)
    ) u_main (
        .clk_i (clk),
        .clr_i (reset),
        .ld_i  (main_ld),
        .ctrl_i(main_ctrl_d),
        .data_i(main_data_d),
        .pc_i  (main_pc_d),
        .rd_i  (main_rd_d),
        .ctrl_o(main_ctrl_q),
        .data_o(out_data),
        .pc_o  (out_pc),
        .rd_o  (out_rd)
    );

    pipe_entry_reg #(
        .DATA_W(DATA_W), .PC_W(PC_W), .RD_W(RD_W), .CTRL_W(CTRL_W)
    ) u_skid (
        .clk_i (clk),
        .clr_i (reset),
        .ld_i  (skid_ld),
        .ctrl_i(in_ctrl),
        .data_i(in_data),
        .pc_i  (in_pc),
        .rd_i  (in_rd),
        .ctrl_o(skid_ctrl_q),
        .data_o(skid_data_q),
        .pc_o  (skid_pc_q),
        .rd_o  (skid_rd_q)
    );

    assign fwd_rd = out_rd;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, fwd_we;
    logic [1:0]  in_ctrl, out_ctrl;
    logic [31:0] in_data, out_data, in_pc, out_pc;
    logic [4:0]  in_rd, out_rd, fwd_rd;
    int          n_chk = 0;
    int          n_fail = 0;

    pipe_stage_skid dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .in_pc    (in_pc),
        .in_rd    (in_rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .out_pc   (out_pc),
        .out_rd   (out_rd),
        .fwd_we   (fwd_we),
        .fwd_rd   (fwd_rd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] d, input logic [4:0] r);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
        in_pc    = d + 32'h1000;
        in_rd    = r;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_fwd_we", fwd_we, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_rd", out_rd, 0);

        // streaming
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 32'h11, 5'd1);
        step();
        chk("s1_valid", out_valid, 1);
        chk("s1_data", out_data, 32'h11);
        chk("s1_pc", out_pc, 32'h1011);
        chk("s1_ready", in_ready, 1);
        drive(1'b1, 2'b01, 32'h22, 5'd2);
        step();
        chk("s2_data", out_data, 32'h22);
        chk("s2_rd", out_rd, 2);
        chk("s2_ready", in_ready, 1);
        drive(1'b1, 2'b01, 32'h33, 5'd3);
        step();
        chk("s3_data", out_data, 32'h33);
        chk("s3_ready", in_ready, 1);
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        step();
        chk("s_drain_valid", out_valid, 0);
        chk("s_drain_ctrl", out_ctrl, 0);

        // backpressure
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'hA, 5'd10);
        step();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_data", out_data, 32'hA);
        chk("bp_a_ready", in_ready, 1);
        drive(1'b1, 2'b00, 32'hB, 5'd11);
        step();
        chk("bp_two_ready", in_ready, 0);
        chk("bp_two_data", out_data, 32'hA);
        drive(1'b1, 2'b00, 32'hC, 5'd12);
        step();
        chk("bp_hold_data", out_data, 32'hA);
        chk("bp_hold_ready", in_ready, 0);
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        out_ready = 1'b1;
        chk("bp_first_out", out_data, 32'hA);
        step();
        chk("bp_second_out", out_data, 32'hB);
        chk("bp_second_rd", out_rd, 11);
        chk("bp_ready_back", in_ready, 1);
        chk("bp_second_valid", out_valid, 1);
        step();
        chk("bp_empty", out_valid, 0);

        // flush in TWO with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'hC1, 5'd3);
        step();
        drive(1'b1, 2'b01, 32'hC2, 5'd4);
        step();
        chk("fl_pre_ready", in_ready, 0);
        flush = 1'b1;
        in_valid = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_fwd_we", fwd_we, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_data_kept", out_data, 32'hC1);
        out_ready = 1'b1;
        step();
        chk("fl_no_leak1", out_valid, 0);
        step();
        chk("fl_no_leak2", out_valid, 0);

        // reset in TWO with flush and input
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'hE1, 5'd5);
        step();
        drive(1'b1, 2'b11, 32'hE2, 5'd6);
        step();
        chk("rt_pre_ready", in_ready, 0);
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 2'b11, 32'hE3, 5'd7);
        step();
        reset = 1'b0; flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        chk("rt_valid", out_valid, 0);
        chk("rt_ready", in_ready, 1);
        chk("rt_ctrl", out_ctrl, 0);
        chk("rt_data", out_data, 0);
        chk("rt_pc", out_pc, 0);
        chk("rt_rd", out_rd, 0);
        chk("rt_fwd_we", fwd_we, 0);
        step();
        chk("rt_stay_empty", out_valid, 0);

        // forwarding
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h77, 5'd7);
        step();
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        chk("fw_we", fwd_we, 1);
        chk("fw_rd", fwd_rd, 7);
        chk("fw_ctrl", out_ctrl, 2'b01);
        step();
        chk("fw_we_held", fwd_we, 1);
        out_ready = 1'b1;
        step();
        chk("fw_we_drained", fwd_we, 0);
        drive(1'b1, 2'b10, 32'h88, 5'd9);
        step();
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        chk("fw_memtoreg_only_we", fwd_we, 0);
        chk("fw_memtoreg_ctrl", out_ctrl, 2'b10);
        chk("fw_memtoreg_rd", fwd_rd, 9);
        step();
        chk("fw_end_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
Parameters:
REQ-001 DATA_W, 32, width of the ALU-result/data field.
REQ-002 PC_W, 32, width of the PC field.
REQ-003 RD_W, 5, width of the destination-register index.
REQ-004 CTRL_W, 2, width of the control bundle (bit0 RegWrite, bit1 MemtoReg; higher bits opaque).

Ports:
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  synchronous kill of all held entries.
REQ-008 in_valid  in  1  upstream entry present.
REQ-009 in_ready  out  1  stage can accept an entry this cycle.
REQ-010 in_ctrl, in_data, in_pc, in_rd  in  CTRL_W/DATA_W/PC_W/RD_W  upstream payload.
REQ-011 out_valid  out  1  downstream entry present.
REQ-012 out_ready  in  1  downstream accepts an entry this cycle.
REQ-013 out_ctrl, out_data, out_pc, out_rd  out  CTRL_W/DATA_W/PC_W/RD_W  payload of the main entry.
REQ-014 fwd_we  out  1  out_valid AND out_ctrl[0], for hazard/forwarding logic.
REQ-015 fwd_rd  out  RD_W  equal to out_rd.

Function
REQ-016 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-017 Storage SHALL consist of a main entry that drives the outputs and a one-entry skid entry.
REQ-018 The state machine SHALL have three states: EMPTY (no entries), ONE (main only), TWO (main and skid).
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, and SHALL be a decode of registered state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-021 EMPTY with in_fire SHALL load main and go to ONE (one-cycle latency from input to output).
REQ-022 ONE with in_fire and out_fire SHALL load main with the new payload and stay in ONE.
REQ-023 ONE with in_fire and no out_fire SHALL load skid and go to TWO, leaving main unchanged.
REQ-024 ONE with out_fire and no in_fire SHALL go to EMPTY.
REQ-025 TWO with out_fire SHALL move skid to main and go to ONE; without out_fire it SHALL hold.
REQ-026 Entries SHALL leave in arrival order, with no loss or duplication.
REQ-027 While out_valid=0, out_ctrl SHALL read all-zero, so a bubble never asserts RegWrite or MemtoReg.
REQ-028 Flush SHALL drop main and skid, go to EMPTY next cycle, and drop any same-cycle in_fire; flush takes priority over all other transitions.
REQ-029 Data, pc and rd fields are not cleared on flush; only out_ctrl is gated to zero.

Reset
REQ-030 When reset=1 at a clk edge, state SHALL become EMPTY and all main and skid fields SHALL be zero.
REQ-031 After reset: out_valid=0, in_ready=1, out_ctrl/out_data/out_pc/out_rd=0, fwd_we=0.
REQ-032 Reset SHALL override flush and any handshake in the same cycle, including mid-transfer in TWO.

Structure
REQ-033 A shared package SHALL hold the state enum (EMPTY/ONE/TWO) and the control-bit index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1).
REQ-034 One sub-module, pipe_entry_reg, SHALL implement a payload register with load enable and synchronous clear, instantiated twice (main and skid).
REQ-035 Existing stage registers (IF/ID … MEM/WB) SHALL be replaceable by this block with parameter overrides only.

Verification
REQ-036 Reset then idle: after reset, out_valid=0, in_ready=1, out_ctrl=0, fwd_we=0.
REQ-037 Streaming with out_ready=1, input 0x11,0x22,0x33 on consecutive cycles: outputs 0x11,0x22,0x33 one cycle later, in_ready stays 1.
REQ-038 Backpressure: out_ready=0, send 0xA then 0xB: state TWO, in_ready=0, out_data=0xA; raise out_ready: 0xA then 0xB delivered, in_ready=1 one cycle after the first out_fire.
REQ-039 Flush in TWO with in_valid=1 and in_ctrl=2'b01: next cycle out_valid=0, out_ctrl=0, fwd_we=0, in_ready=1; the flushed input never appears at the output.
REQ-040 Reset asserted in TWO together with flush and in_valid: next cycle all outputs are zero, out_valid=0, in_ready=1.
REQ-041 Forwarding: accept ctrl=2'b01, rd=5'd7 → fwd_we=1, fwd_rd=7 while held; after drain, fwd_we=0.
